voice_scheduler: RTL and testbench

//   Time-multiplexes the single-port, 1-cycle-latency sample ROM among VOICES playback voices.
//   - Once per audio frame (tick): reads one sample per active voice, sums them, emits one mixed sample.
//   - Sits between the note/trigger logic and the DAC/PWM output stage.

---
 rtl/music_pkg.sv | 16 +
 rtl/voice_state.sv | 47 ++++
 rtl/voice_scheduler.sv | 113 +++++++++++
 tb/tb_voice_scheduler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/music_pkg.sv
// Shared types and helpers for the voice scheduler.
package music_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    // Guard bits so that summing n full-scale samples cannot overflow.
    function automatic int guard_bits(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/voice_state.sv
// Per-voice note registers: trigger capture, position advance and end-of-note handling.
// VOICE_LOOP_EN: when defined, a note wraps to its start instead of stopping.
module voice_state #(
    parameter int ADDR = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            trig,
    input  logic [ADDR-1:0] start,
    input  logic [ADDR-1:0] len,
    input  logic            adv,
    output logic [ADDR-1:0] cur_addr,
    output logic            active
);

    logic [ADDR-1:0] start_q;
    logic [ADDR-1:0] len_q;
    logic [ADDR-1:0] pos;

    // A trigger takes priority over the advance of the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= '0;
            len_q   <= '0;
            pos     <= '0;
            active  <= 1'b0;
        end else if (trig && (len != '0)) begin
            start_q <= start;
            len_q   <= len;
            pos     <= '0;
            active  <= 1'b1;
        end else if (adv && active) begin
            if (pos == len_q - 1'b1) begin
`ifdef VOICE_LOOP_EN
                pos <= '0;
`else
                active <= 1'b0;
`endif
            end else begin
                pos <= pos + 1'b1;
            end
        end
    end

    assign cur_addr = start_q + pos;

endmodule

// File: rtl/voice_scheduler.sv
// Shares a 1-cycle-latency sample ROM among VOICES voices and mixes one sample per frame.
// VOICE_LOOP_EN: selects looping voices (default build plays each note once).
module voice_scheduler
    import music_pkg::*;
#(
    parameter int VOICES    = 4,
    parameter int WIDTH     = 20,
    parameter int ADDR      = 16,
    parameter int OUT_WIDTH = WIDTH + guard_bits(VOICES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [VOICES-1:0]           trig,
    input  logic [VOICES*ADDR-1:0]      trig_start,
    input  logic [VOICES*ADDR-1:0]      trig_len,
    output logic [ADDR-1:0]             rom_addr,
    input  logic signed [WIDTH-1:0]     rom_data,
    output logic signed [OUT_WIDTH-1:0] mix,
    output logic                        mix_valid,
    output logic [VOICES-1:0]           active,
    output logic                        busy,
    output logic                        overrun
);

    localparam int VW = (VOICES > 1) ? $clog2(VOICES) : 1;

    sched_state_t state, state_nxt;
    logic [VW-1:0]   slot;
    logic            drain_cnt;
    logic            start_frame, issue_en, frame_done, last_slot;
    logic            pipe1, pipe2;
    logic signed [OUT_WIDTH-1:0] acc;
    logic [ADDR-1:0] addr_arr [VOICES];

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        voice_state #(.ADDR(ADDR)) u_voice (
            .clk      (clk),
            .rst      (rst),
            .trig     (trig[v]),
            .start    (trig_start[v*ADDR +: ADDR]),
            .len      (trig_len[v*ADDR +: ADDR]),
            .adv      (issue_en && (slot == VW'(v))),
            .cur_addr (addr_arr[v]),
            .active   (active[v])
        );
    end

    assign last_slot = (slot == VW'(VOICES - 1));
    assign busy      = (state != S_IDLE);

    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        issue_en    = 1'b0;
        frame_done  = 1'b0;
        unique case (state)
            S_IDLE:  if (tick) begin
                         start_frame = 1'b1;
                         state_nxt   = S_ISSUE;
                     end
            S_ISSUE: begin
                         issue_en = 1'b1;
                         if (last_slot) state_nxt = S_DRAIN;
                     end
            S_DRAIN: if (drain_cnt == 1'b0) state_nxt = S_DONE;
            S_DONE:  begin
                         frame_done = 1'b1;
                         state_nxt  = S_IDLE;
                     end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            slot      <= '0;
            drain_cnt <= 1'b0;
            pipe1     <= 1'b0;
            pipe2     <= 1'b0;
            acc       <= '0;
            rom_addr  <= '0;
            mix       <= '0;
            mix_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            mix_valid <= frame_done;
            overrun   <= tick && busy;
            if (start_frame)
                slot <= '0;
            else if (issue_en)
                slot <= slot + 1'b1;
            // Two drain cycles cover ROM latency plus the accumulate stage.
            if (issue_en && last_slot)
                drain_cnt <= 1'b1;
            else if (state == S_DRAIN)
                drain_cnt <= drain_cnt - 1'b1;
            if (issue_en)
                rom_addr <= addr_arr[slot];
            pipe1 <= issue_en && active[slot];
            pipe2 <= pipe1;
            if (start_frame)
                acc <= '0;
            else if (pipe2)
                acc <= acc + OUT_WIDTH'(rom_data);
            if (frame_done)
                mix <= acc;
        end
    end

endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: expected mixes queued by stimulus, checked by a monitor.
module tb_voice_scheduler;

    localparam int VOICES = 4;
    localparam int WIDTH  = 20;
    localparam int ADDR   = 16;
    localparam int OW     = WIDTH + 2;
    localparam int LAT    = VOICES + 3;

    typedef struct {
        int mix;
        int t0;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   tick = 1'b0;
    logic [VOICES-1:0]      trig = '0;
    logic [VOICES*ADDR-1:0] trig_start = '0;
    logic [VOICES*ADDR-1:0] trig_len = '0;
    logic [ADDR-1:0]        rom_addr;
    logic signed [WIDTH-1:0] rom_data = '0;
    logic signed [OW-1:0]   mix;
    logic                   mix_valid;
    logic [VOICES-1:0]      active;
    logic                   busy;
    logic                   overrun;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   ovr_cnt = 0;
    int   mv_cnt = 0;
    exp_t sb[$];

    voice_scheduler dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .trig       (trig),
        .trig_start (trig_start),
        .trig_len   (trig_len),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .mix        (mix),
        .mix_valid  (mix_valid),
        .active     (active),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    // ROM holds ram[i] = i, one cycle of read latency.
    always @(posedge clk) begin
        rom_data <= WIDTH'(rom_addr);
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (overrun) ovr_cnt++;
        if (mix_valid) begin
            mv_cnt++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_mix_valid: got mix=%0d, no frame expected", mix);
            end else begin
                e = sb.pop_front();
                if (mix !== OW'(e.mix)) begin
                    errors++;
                    $display("FAIL mix_value: got %0d, expected %0d", mix, e.mix);
                end
                checks++;
                if (cyc - e.t0 != LAT) begin
                    errors++;
                    $display("FAIL mix_latency: got %0d cycles, expected %0d", cyc - e.t0, LAT);
                end
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic set_voice(input int v, input int start, input int len);
        trig_start[v*ADDR +: ADDR] = ADDR'(start);
        trig_len[v*ADDR +: ADDR]   = ADDR'(len);
    endtask

    task automatic pulse_trig(input logic [VOICES-1:0] m);
        @(posedge clk); #1;
        trig = m;
        @(posedge clk); #1;
        trig = '0;
    endtask

    task automatic pulse_tick();
        @(posedge clk); #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
    endtask

    task automatic run_frame(input int exp_mix);
        exp_t e;
        @(posedge clk); #1;
        e.mix = exp_mix;
        e.t0  = cyc + 1;
        sb.push_back(e);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (9) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   mv0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset state and an empty frame
        check("reset_mix", int'(mix), 0);
        check("reset_mix_valid", int'(mix_valid), 0);
        check("reset_active", int'(active), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_rom_addr", int'(rom_addr), 0);
        check("reset_overrun", int'(overrun), 0);
        run_frame(0);
        check("t1_active", int'(active), 0);
        check("t1_overrun_count", ovr_cnt, 0);

        // 2: one-shot note of length 3
        set_voice(0, 10, 3);
        pulse_trig(4'b0001);
        check("t2_active_after_trig", int'(active), 1);
        run_frame(10);
        run_frame(11);
        check("t2_active_mid", int'(active), 1);
        run_frame(12);
        check("t2_active_end", int'(active), 0);
        run_frame(0);

        // len=0 trigger is ignored
        set_voice(3, 500, 0);
        pulse_trig(4'b1000);
        check("len0_ignored", int'(active), 0);

        // 3: two voices triggered together
        set_voice(0, 100, 8);
        set_voice(2, 200, 8);
        pulse_trig(4'b0101);
        check("t3_active", int'(active), 5);
        run_frame(300);
        run_frame(302);

        // 4: tick while busy
        mv0 = mv_cnt;
        @(posedge clk); #1;
        e.mix = 304;
        e.t0  = cyc + 1;
        sb.push_back(e);
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tick = 1'b1;
        @(posedge clk); #1;
        tick = 1'b0;
        check("t4_overrun_now", int'(overrun), 1);
        repeat (10) @(posedge clk);
        #1;
        check("t4_overrun_count", ovr_cnt, 1);
        check("t4_single_mix_valid", mv_cnt - mv0, 1);
        run_frame(306);

        // 5: two-sample note, looping or one-shot by build
        do_reset();
        set_voice(1, 5, 2);
        pulse_trig(4'b0010);
        run_frame(5);
        run_frame(6);
`ifdef VOICE_LOOP_EN
        run_frame(5);
        run_frame(6);
        run_frame(5);
        check("t5_active", int'(active), 2);
`else
        run_frame(0);
        run_frame(0);
        run_frame(0);
        check("t5_active", int'(active), 0);
`endif

        // 6: reset during ISSUE aborts the frame
        set_voice(0, 50, 4);
        pulse_trig(4'b0001);
        mv0 = mv_cnt;
        pulse_tick();
        @(posedge clk); #1;
        check("t6_busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("t6_no_mix_valid", mv_cnt - mv0, 0);
        check("t6_mix", int'(mix), 0);
        check("t6_active", int'(active), 0);
        check("t6_busy", int'(busy), 0);
        run_frame(0);
        set_voice(0, 50, 4);
        pulse_trig(4'b0001);
        run_frame(50);
        run_frame(51);

        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
